// File: rtl/game_ctrl.sv
// Game-state controller: button conditioning, per-frame collision/score, IDLE/PLAY/DEAD sequencing.
// Latency: button -> o_flap/state change 3 edges after i_btn is first sampled; collision/score on the frame-strobe edge.
// Backpressure: none; i_frame_stb and i_btn are sampled every cycle, and presses during lockout are dropped.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_frame_stb           one-cycle strobe per frame
//   i_btn                 raw asynchronous button level
//   i_bx1..i_by2          bird box (left, right, top, bottom)
//   i_px1, i_px2          current pipe left/right edge
//   i_gy1, i_gy2          pipe gap top/bottom edge
//   o_flap                one-cycle flap pulse to bird
//   o_bird_rst            hold-reset to bird (high in IDLE)
//   o_animate             bird animate enable (high in PLAY)
//   o_state               00 IDLE, 01 PLAY, 10 DEAD
//   o_score               two-digit BCD score
module game_ctrl #(
    parameter int FLOOR_Y        = 450,
    parameter int DEAD_FRAMES    = 60,
    parameter int LOCKOUT_FRAMES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_stb,
    input  logic        i_btn,
    input  logic [11:0] i_bx1,
    input  logic [11:0] i_bx2,
    input  logic [11:0] i_by1,
    input  logic [11:0] i_by2,
    input  logic [11:0] i_px1,
    input  logic [11:0] i_px2,
    input  logic [11:0] i_gy1,
    input  logic [11:0] i_gy2,
    output logic        o_flap,
    output logic        o_bird_rst,
    output logic        o_animate,
    output logic [1:0]  o_state,
    output logic [7:0]  o_score
);

    localparam int LW = $clog2(LOCKOUT_FRAMES + 1);
    localparam int DW = $clog2(DEAD_FRAMES + 1);
    localparam logic [11:0] FLOOR = 12'(FLOOR_Y);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    state_t          state, state_nxt;
    logic            btn_s1, btn_s2, btn_prev;
    logic [LW-1:0]   lock_cnt, lock_nxt;
    logic [DW-1:0]   dead_cnt, dead_nxt;
    logic [7:0]      score, score_nxt;
    logic            passed, passed_nxt;
    logic            flap_nxt;

    logic btn_edge, accept, hit, pipe_behind;

    assign btn_edge    = btn_s2 & ~btn_prev;
    assign accept      = btn_edge & (lock_cnt == '0);
    assign pipe_behind = i_px2 < i_bx1;
    assign hit         = i_frame_stb &
                         ((i_by2 >= FLOOR) |
                          ((i_bx2 > i_px1) & (i_bx1 < i_px2) &
                           ((i_by1 < i_gy1) | (i_by2 > i_gy2))));

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_nxt  = state;
        score_nxt  = score;
        passed_nxt = passed;
        dead_nxt   = dead_cnt;
        flap_nxt   = 1'b0;
        lock_nxt   = lock_cnt;

        // Lockout runs in every state so a press that ends DEAD also
        // guards against bounce into the following IDLE press.
        if (accept)
            lock_nxt = LW'(LOCKOUT_FRAMES);
        else if (i_frame_stb && lock_cnt != '0)
            lock_nxt = lock_cnt - LW'(1);

        // Pipe has wrapped back in front of the bird: arm scoring again.
        if (i_frame_stb && !pipe_behind)
            passed_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt  = S_PLAY;
                    score_nxt  = 8'h00;
                    passed_nxt = 1'b0;
                    flap_nxt   = 1'b1;
                end
            end
            S_PLAY: begin
                if (hit) begin
                    // Death wins over both a flap and a score in the same cycle.
                    state_nxt = S_DEAD;
                    dead_nxt  = DW'(DEAD_FRAMES);
                end else begin
                    flap_nxt = accept;
                    if (i_frame_stb && pipe_behind && !passed) begin
                        score_nxt  = bcd_inc(score);
                        passed_nxt = 1'b1;
                    end
                end
            end
            S_DEAD: begin
                if (i_frame_stb && dead_cnt != '0)
                    dead_nxt = dead_cnt - DW'(1);
                // Uses the registered count, so a press in the cycle the
                // counter reaches zero is not honoured.
                if (accept && dead_cnt == '0)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            btn_s1     <= 1'b0;
            btn_s2     <= 1'b0;
            btn_prev   <= 1'b0;
            lock_cnt   <= '0;
            dead_cnt   <= '0;
            score      <= 8'h00;
            passed     <= 1'b0;
            o_flap     <= 1'b0;
            o_bird_rst <= 1'b1;
            o_animate  <= 1'b0;
        end else begin
            state      <= state_nxt;
            btn_s1     <= i_btn;
            btn_s2     <= btn_s1;
            btn_prev   <= btn_s2;
            lock_cnt   <= lock_nxt;
            dead_cnt   <= dead_nxt;
            score      <= score_nxt;
            passed     <= passed_nxt;
            o_flap     <= flap_nxt;
            o_bird_rst <= (state_nxt == S_IDLE);
            o_animate  <= (state_nxt == S_PLAY);
        end
    end

    assign o_state = state;
    assign o_score = score;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_frame_stb = 1'b0;
    logic        i_btn = 1'b0;
    logic [11:0] i_bx1 = '0, i_bx2 = '0, i_by1 = '0, i_by2 = '0;
    logic [11:0] i_px1 = '0, i_px2 = '0, i_gy1 = '0, i_gy2 = '0;
    logic        o_flap, o_bird_rst, o_animate;
    logic [1:0]  o_state;
    logic [7:0]  o_score;

    localparam logic [1:0] IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10;

    game_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_stb(i_frame_stb), .i_btn(i_btn),
        .i_bx1(i_bx1), .i_bx2(i_bx2), .i_by1(i_by1), .i_by2(i_by2),
        .i_px1(i_px1), .i_px2(i_px2), .i_gy1(i_gy1), .i_gy2(i_gy2),
        .o_flap(o_flap), .o_bird_rst(o_bird_rst), .o_animate(o_animate),
        .o_state(o_state), .o_score(o_score)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int flap_cnt = 0;

    always @(negedge i_clk) if (o_flap === 1'b1) flap_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected architectural outputs.
    typedef struct {
        string      name;
        logic [1:0] st;
        logic [7:0] sc;
    } exp_t;
    exp_t sb[$];

    task automatic expect_out(input string name, input logic [1:0] st, input logic [7:0] sc);
        exp_t e;
        e.name = name; e.st = st; e.sc = sc;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".state"},    32'(o_state),    32'(e.st));
            chk({e.name, ".score"},    32'(o_score),    32'(e.sc));
            chk({e.name, ".animate"},  32'(o_animate),  32'(e.st == PLAY));
            chk({e.name, ".bird_rst"}, 32'(o_bird_rst), 32'(e.st == IDLE));
        end
    endtask

    task automatic set_geom(input logic [11:0] bx1, bx2, by1, by2, px1, px2, gy1, gy2);
        i_bx1 = bx1; i_bx2 = bx2; i_by1 = by1; i_by2 = by2;
        i_px1 = px1; i_px2 = px2; i_gy1 = gy1; i_gy2 = gy2;
    endtask

    task automatic frame(input logic [11:0] bx1, bx2, by1, by2, px1, px2, gy1, gy2);
        @(negedge i_clk);
        set_geom(bx1, bx2, by1, by2, px1, px2, gy1, gy2);
        i_frame_stb = 1'b1;
        @(negedge i_clk);
        i_frame_stb = 1'b0;
    endtask

    // Bird safely inside the gap; px2=200 puts the pipe behind the bird.
    task automatic frame_safe(input logic [11:0] px2);
        frame(12'd240, 12'd280, 12'd180, 12'd210, px2 - 12'd60, px2, 12'd150, 12'd250);
    endtask

    task automatic pass_pipe();
        frame_safe(12'd700);
        frame_safe(12'd200);
    endtask

    task automatic press();
        @(negedge i_clk);
        i_btn = 1'b1;
        repeat (3) @(negedge i_clk);
        i_btn = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    // Press whose detected edge lands in the same cycle as a frame strobe.
    task automatic press_on_strobe(input logic [11:0] bx1, bx2, by1, by2, px1, px2, gy1, gy2);
        @(negedge i_clk);
        i_btn = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        set_geom(bx1, bx2, by1, by2, px1, px2, gy1, gy2);
        i_frame_stb = 1'b1;
        @(negedge i_clk);
        i_frame_stb = 1'b0;
        i_btn = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    typedef struct {
        string       name;
        logic [11:0] bx1, bx2, by1, by2, px1, px2, gy1, gy2;
        logic [1:0]  st;
        logic [7:0]  sc;
    } vec_t;
    vec_t vecs[10];

    task automatic set_vec(input int i, input string name,
                           input logic [11:0] bx1, bx2, by1, by2, px1, px2, gy1, gy2,
                           input logic [1:0] st, input logic [7:0] sc);
        vecs[i].name = name;
        vecs[i].bx1 = bx1; vecs[i].bx2 = bx2; vecs[i].by1 = by1; vecs[i].by2 = by2;
        vecs[i].px1 = px1; vecs[i].px2 = px2; vecs[i].gy1 = gy1; vecs[i].gy2 = gy2;
        vecs[i].st = st; vecs[i].sc = sc;
    endtask

    initial begin
        int f0;
        //            name          bx1  bx2  by1  by2  px1  px2  gy1  gy2  state score
        set_vec(0, "v_above_gap",   280, 320, 100, 130, 300, 360, 150, 250, DEAD, 8'h00);
        set_vec(1, "v_in_gap",      280, 320, 180, 210, 300, 360, 150, 250, PLAY, 8'h00);
        set_vec(2, "v_below_gap",   280, 320, 230, 260, 300, 360, 150, 250, DEAD, 8'h00);
        set_vec(3, "v_floor_eq",    280, 320, 400, 450, 600, 660, 150, 250, DEAD, 8'h00);
        set_vec(4, "v_floor_m1",    280, 320, 400, 449, 600, 660, 150, 250, PLAY, 8'h00);
        set_vec(5, "v_bx2_eq_px1",  260, 300, 100, 130, 300, 360, 150, 250, PLAY, 8'h00);
        set_vec(6, "v_bx1_eq_px2",  360, 400, 100, 130, 300, 360, 150, 250, PLAY, 8'h00);
        set_vec(7, "v_passed",      240, 280, 100, 130, 150, 200, 150, 250, PLAY, 8'h01);
        set_vec(8, "v_gap_edges",   280, 320, 150, 250, 300, 360, 150, 250, PLAY, 8'h00);
        set_vec(9, "v_floor_pass",  240, 280, 400, 460, 150, 200, 150, 250, DEAD, 8'h00);

        // Reset state
        repeat (2) @(negedge i_clk);
        expect_out("reset", IDLE, 8'h00);
        check_sb();
        chk("reset.flap", 32'(o_flap), 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Button latency: o_flap appears right after the third sampling edge
        i_btn = 1'b1;
        @(posedge i_clk); #1;
        chk("lat.e0.flap", 32'(o_flap), 32'd0);
        @(posedge i_clk); #1;
        chk("lat.e1.flap", 32'(o_flap), 32'd0);
        chk("lat.e1.state", 32'(o_state), 32'(IDLE));
        @(posedge i_clk); #1;
        chk("lat.e2.flap", 32'(o_flap), 32'd1);
        expect_out("lat.e2", PLAY, 8'h00);
        check_sb();
        i_btn = 1'b0;
        @(posedge i_clk); #1;
        chk("lat.e3.flap", 32'(o_flap), 32'd0);
        repeat (3) @(negedge i_clk);

        // Lockout: one score on the way, then presses 1 frame apart
        frame_safe(12'd700); frame_safe(12'd700); frame_safe(12'd200); frame_safe(12'd700);
        expect_out("lock.pre", PLAY, 8'h01);
        check_sb();
        f0 = flap_cnt;
        press();
        chk("lock.first", 32'(flap_cnt - f0), 32'd1);
        frame_safe(12'd700);
        press();
        chk("lock.blocked", 32'(flap_cnt - f0), 32'd1);
        repeat (3) frame_safe(12'd700);
        press();
        chk("lock.after4", 32'(flap_cnt - f0), 32'd2);
        repeat (4) frame_safe(12'd700);

        // Hit and press on the same strobe: DEAD, no flap
        f0 = flap_cnt;
        press_on_strobe(12'd280, 12'd320, 12'd100, 12'd130, 12'd300, 12'd360, 12'd150, 12'd250);
        chk("hitpress.flap", 32'(flap_cnt - f0), 32'd0);
        expect_out("hitpress", DEAD, 8'h01);
        check_sb();

        // Dead counter
        repeat (55) frame_safe(12'd700);
        press();
        expect_out("dead.early", DEAD, 8'h01);
        check_sb();
        repeat (4) frame_safe(12'd700);
        press_on_strobe(12'd240, 12'd280, 12'd180, 12'd210, 12'd640, 12'd700, 12'd150, 12'd250);
        expect_out("dead.same_cycle", DEAD, 8'h01);
        check_sb();
        repeat (4) frame_safe(12'd700);
        press();
        expect_out("dead.to_idle", IDLE, 8'h01);
        check_sb();
        chk("dead.noflap", 32'(flap_cnt - f0), 32'd0);
        repeat (4) frame_safe(12'd700);
        press();
        expect_out("restart", PLAY, 8'h00);
        check_sb();
        chk("restart.flap", 32'(flap_cnt - f0), 32'd1);

        // Scoring: approaching pipe passes once
        frame_safe(12'd400); frame_safe(12'd300); frame_safe(12'd200); frame_safe(12'd200);
        expect_out("score.once", PLAY, 8'h01);
        check_sb();
        pass_pipe();
        expect_out("score.wrap", PLAY, 8'h02);
        check_sb();
        repeat (7) pass_pipe();
        expect_out("score.09", PLAY, 8'h09);
        check_sb();
        pass_pipe();
        expect_out("score.10", PLAY, 8'h10);
        check_sb();
        repeat (32) pass_pipe();
        expect_out("score.42", PLAY, 8'h42);
        check_sb();

        // Asynchronous reset mid-PLAY
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        expect_out("midrst", IDLE, 8'h00);
        check_sb();
        chk("midrst.flap", 32'(o_flap), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        press();
        repeat (99) pass_pipe();
        expect_out("score.99", PLAY, 8'h99);
        check_sb();
        pass_pipe();
        expect_out("score.sat", PLAY, 8'h99);
        check_sb();

        // Collision / score table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            f0 = flap_cnt;
            press();
            chk({vecs[i].name, ".flap"}, 32'(flap_cnt - f0), 32'd1);
            frame(vecs[i].bx1, vecs[i].bx2, vecs[i].by1, vecs[i].by2,
                  vecs[i].px1, vecs[i].px2, vecs[i].gy1, vecs[i].gy2);
            expect_out(vecs[i].name, vecs[i].st, vecs[i].sc);
            check_sb();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
